timing_gen: RTL and testbench

Drum timing generator for the G-15 CPU. It counts drum bit pulses into a bit-time counter (29 bit times per word) and a word-time counter (WORDS words per revolution), and it locks to the drum's origin index mark. It decodes the counters into the bit-time and word-time strobes that feed the CPU top level (T0, T1, T2, T13, T21, T28, T29, TE, TF, TS). It sits directly upstream of the CPU and reports lock state and sync errors to the maintenance logic.

---
 rtl/timing_gen.sv | 132 +++++++++++++
 tb/tb_timing_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/timing_gen.sv
// Drum timing generator: counts drum bit pulses into bit-time (0..28) and
// word-time (0..WORDS-1) counters, locks to the drum origin index mark, and
// decodes the counters into the bit/word strobes used by the CPU.
module timing_gen #(
    parameter int WORDS = 108
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       bit_en,
    input  logic       drum_index,
    input  logic       err_clr,
    output logic       T0,
    output logic       T1,
    output logic       T2,
    output logic       T13,
    output logic       T21,
    output logic       T28,
    output logic       T29,
    output logic       TE,
    output logic       TF,
    output logic       TS,
    output logic [6:0] word_time,
    output logic [4:0] bit_time,
    output logic       locked,
    output logic       sync_err
);

    typedef enum logic {
        S_SEARCH = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    localparam logic [4:0] BC_LAST = 5'd28;
    localparam logic [6:0] WC_LAST = 7'(WORDS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_bc;
    logic [4:0] w_bc_nxt;
    logic [6:0] r_wc;
    logic [6:0] w_wc_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic       w_locked;
    logic       w_bc_last;
    logic       w_at_end;

    assign w_locked  = (r_state == S_LOCKED);
    assign w_bc_last = (r_bc == BC_LAST);
    // The only position where an index mark is legal while locked.
    assign w_at_end  = w_bc_last && (r_wc == WC_LAST);

    // State, counter and sticky error registers; reset aborts any word in flight.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            r_state <= S_SEARCH;
            r_bc    <= 5'd0;
            r_wc    <= 7'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bc    <= w_bc_nxt;
            r_wc    <= w_wc_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state, counter advance and index checking; a new error beats err_clr.
    always_comb begin
        w_state_nxt = r_state;
        w_bc_nxt    = r_bc;
        w_wc_nxt    = r_wc;
        w_err_nxt   = err_clr ? 1'b0 : r_err;
        case (r_state)
            S_SEARCH: begin
                w_bc_nxt = 5'd0;
                w_wc_nxt = 7'd0;
                if (bit_en && drum_index) begin
                    w_state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (bit_en) begin
                    if (w_at_end) begin
                        w_bc_nxt = 5'd0;
                        w_wc_nxt = 7'd0;
                        if (!drum_index) begin
                            // Missing index: drop lock and hunt for the mark again.
                            w_state_nxt = S_SEARCH;
                            w_err_nxt   = 1'b1;
                        end
                    end else if (drum_index) begin
                        // Early index: resynchronise to the mark but stay locked.
                        w_bc_nxt  = 5'd0;
                        w_wc_nxt  = 7'd0;
                        w_err_nxt = 1'b1;
                    end else if (w_bc_last) begin
                        w_bc_nxt = 5'd0;
                        w_wc_nxt = 7'(r_wc + 7'd1);
                    end else begin
                        w_bc_nxt = 5'(r_bc + 5'd1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_SEARCH;
                w_bc_nxt    = 5'd0;
                w_wc_nxt    = 7'd0;
            end
        endcase
    end

    // Strobe decode from registered state only; everything is gated off while searching.
    always_comb begin
        T0  = w_locked && (r_bc == 5'd28);
        T1  = w_locked && (r_bc == 5'd0);
        T2  = w_locked && (r_bc == 5'd1);
        T13 = w_locked && (r_bc == 5'd12);
        T21 = w_locked && (r_bc == 5'd20);
        T28 = w_locked && (r_bc == 5'd27);
        T29 = w_locked && (r_bc == 5'd28);
        TE  = w_locked && !r_wc[0];
        TF  = w_locked && (r_wc == WC_LAST);
        TS  = w_locked && (r_wc[1:0] == 2'b11);
    end

    assign word_time = r_wc;
    assign bit_time  = r_bc;
    assign locked    = w_locked;
    assign sync_err  = r_err;

endmodule

// File: tb/tb_timing_gen.sv
// Directed bench for timing_gen with a scoreboard of expected output vectors.
module tb_timing_gen;

    localparam int W    = 4;
    localparam int LAST = W * 29 - 1;

    logic       CLOCK = 1'b0;
    logic       rst = 1'b1;
    logic       bit_en = 1'b0;
    logic       drum_index = 1'b0;
    logic       err_clr = 1'b0;
    logic       T0, T1, T2, T13, T21, T28, T29, TE, TF, TS, locked, sync_err;
    logic [6:0] word_time;
    logic [4:0] bit_time;

    typedef struct packed {
        logic       t0, t1, t2, t13, t21, t28, t29, te, tf, ts, lk, se;
        logic [6:0] wt;
        logic [4:0] bt;
    } obs_t;

    obs_t dut_obs;
    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_lk = 0;
    int   m_pos = 0;
    int   m_err = 0;

    assign dut_obs = {T0, T1, T2, T13, T21, T28, T29, TE, TF, TS, locked, sync_err,
                      word_time, bit_time};

    always #5 CLOCK = ~CLOCK;

    timing_gen #(.WORDS(W)) dut (
        .CLOCK(CLOCK), .rst(rst), .bit_en(bit_en), .drum_index(drum_index),
        .err_clr(err_clr), .T0(T0), .T1(T1), .T2(T2), .T13(T13), .T21(T21),
        .T28(T28), .T29(T29), .TE(TE), .TF(TF), .TS(TS), .word_time(word_time),
        .bit_time(bit_time), .locked(locked), .sync_err(sync_err)
    );

    function automatic obs_t model_obs();
        obs_t o;
        int   bc;
        int   wc;
        o  = '0;
        bc = m_pos % 29;
        wc = m_pos / 29;
        o.se = (m_err != 0);
        if (m_lk != 0) begin
            o.lk  = 1'b1;
            o.wt  = 7'(wc);
            o.bt  = 5'(bc);
            o.t0  = (bc == 28);
            o.t1  = (bc == 0);
            o.t2  = (bc == 1);
            o.t13 = (bc == 12);
            o.t21 = (bc == 20);
            o.t28 = (bc == 27);
            o.t29 = (bc == 28);
            o.te  = (wc % 2 == 0);
            o.tf  = (wc == W - 1);
            o.ts  = (wc % 4 == 3);
        end
        return o;
    endfunction

    // Reference behaviour on a linear drum position 0..LAST.
    task automatic model_step(input logic en, input logic idx, input logic clr);
        int set_err;
        set_err = 0;
        if (m_lk == 0) begin
            if (en && idx) begin
                m_lk  = 1;
                m_pos = 0;
            end
        end else if (en) begin
            if (m_pos == LAST) begin
                m_pos = 0;
                if (!idx) begin
                    m_lk    = 0;
                    set_err = 1;
                end
            end else if (idx) begin
                m_pos   = 0;
                set_err = 1;
            end else begin
                m_pos = m_pos + 1;
            end
        end
        if (set_err != 0) m_err = 1;
        else if (clr) m_err = 0;
    endtask

    task automatic step(input logic en, input logic idx, input logic clr);
        obs_t e;
        bit_en     = en;
        drum_index = idx;
        err_clr    = clr;
        model_step(en, idx, clr);
        exp_q.push_back(model_obs());
        @(posedge CLOCK);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        assert (dut_obs === e) else begin
            n_bad++;
            $error("FAIL sb got=%h exp=%h", dut_obs, e);
        end
        bit_en     = 1'b0;
        drum_index = 1'b0;
        err_clr    = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // Power-on reset
        #3;
        chk("reset_all_zero", 32'(dut_obs), 32'd0);
        @(negedge CLOCK);
        rst = 1'b0;

        // bit_en without index while searching
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        chk("search_zero", 32'(dut_obs), 32'd0);

        // Lock and count
        step(1'b1, 1'b1, 1'b0);
        chk("lock_locked", 32'(locked), 32'd1);
        chk("lock_t1", 32'(T1), 32'd1);
        chk("lock_te", 32'(TE), 32'd1);
        chk("lock_ts", 32'(TS), 32'd0);
        chk("lock_wt", 32'(word_time), 32'd0);
        for (int i = 1; i <= 115; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i % 7 == 0) step(1'b0, 1'b1, 1'b0);
            if (i == 87) begin
                chk("w3_wt", 32'(word_time), 32'd3);
                chk("w3_t1", 32'(T1), 32'd1);
                chk("w3_tf", 32'(TF), 32'd1);
                chk("w3_ts", 32'(TS), 32'd1);
                chk("w3_te", 32'(TE), 32'd0);
            end
        end
        chk("end_wt", 32'(word_time), 32'd3);
        chk("end_t0", 32'(T0), 32'd1);
        chk("end_t29", 32'(T29), 32'd1);
        chk("end_err", 32'(sync_err), 32'd0);

        // Normal wrap over three revolutions, bit_en back-to-back
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("wrap_pos", 32'({word_time, bit_time}), 32'd0);
            chk("wrap_t1", 32'(T1), 32'd1);
            chk("wrap_te", 32'(TE), 32'd1);
            chk("wrap_lk", 32'(locked), 32'd1);
            chk("wrap_err", 32'(sync_err), 32'd0);
            for (int i = 0; i < 115; i++) step(1'b1, 1'b0, 1'b0);
        end

        // Missing index at the end position
        step(1'b1, 1'b0, 1'b0);
        chk("miss_lk", 32'(locked), 32'd0);
        chk("miss_strobes", 32'({T0, T1, T2, T13, T21, T28, T29, TE, TF, TS}), 32'd0);
        chk("miss_err", 32'(sync_err), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("relock_lk", 32'(locked), 32'd1);
        chk("relock_pos", 32'({word_time, bit_time}), 32'd0);

        // Early index at word 1, bit 12 (T13)
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 41; i++) step(1'b1, 1'b0, 1'b0);
        chk("pre_early_t13", 32'(T13), 32'd1);
        chk("pre_early_wt", 32'(word_time), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("early_pos", 32'({word_time, bit_time}), 32'd0);
        chk("early_t1", 32'(T1), 32'd1);
        chk("early_err", 32'(sync_err), 32'd1);
        chk("early_lk", 32'(locked), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("clr_err", 32'(sync_err), 32'd0);

        // err_clr together with an early index: the error wins
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("simul_err", 32'(sync_err), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("noevent_err", 32'(sync_err), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("clr2_err", 32'(sync_err), 32'd0);

        // Asynchronous reset mid-word, between clock edges
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 32'(dut_obs), 32'd0);
        m_lk  = 0;
        m_pos = 0;
        m_err = 0;
        @(negedge CLOCK);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("post_rst_lock", 32'(locked), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
